alu64bit_issue_seq: RTL and testbench

- Request sequencer directly upstream of the 64-bit ALU (alu64bit).
- Accepts one operation at a time over a valid/ready handshake and registers the operands, carry-in and op onto the ALU inputs.
- Waits an op-dependent number of settle cycles for the slow ALU datapath, then captures s/cout into a result register held under a valid/ready handshake.
- Counts completed operations.

---
 rtl/alu64bit_issue_seq.sv | 107 ++++++++++
 tb/tb_alu64bit_issue_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu64bit_issue_seq.sv
// alu64bit_issue_seq: one-at-a-time request sequencer feeding the 64-bit ALU
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_cin/in_op request side;
//   alu_a/alu_b/alu_cin/alu_op drive the ALU, alu_s/alu_cout come back after the settle time;
//   res_valid/res_ready/res_s/res_cout/res_op result side; ops_done counts result transfers;
//   chk_err is the sticky model-mismatch flag, built only with ALU64BIT_ISSUE_SEQ_CHECK_EN.
module alu64bit_issue_seq #(
  parameter int W = 64,
  parameter int LOGIC_WAIT = 3,
  parameter int ARITH_WAIT = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic [W-1:0]     alu_s,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_s,
  output logic             res_cout,
  output logic [1:0]       res_op,
  output logic [CNT_W-1:0] ops_done,
  output logic             chk_err
);
  if (LOGIC_WAIT < 1 || LOGIC_WAIT > 255) begin : g_bad_logic_wait
    $error("LOGIC_WAIT must be 1..255");
  end
  if (ARITH_WAIT < 1 || ARITH_WAIT > 255) begin : g_bad_arith_wait
    $error("ARITH_WAIT must be 1..255");
  end
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state;
  logic [7:0] cnt;
  logic up;
  logic capture;
  // up holds in_ready low until the first edge after reset release
  assign in_ready = up && state == IDLE;
  assign capture = state == SETTLE && cnt == 8'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      up <= 1'b0;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_cin <= 1'b0;
      alu_op <= '0;
      res_valid <= 1'b0;
      res_s <= '0;
      res_cout <= 1'b0;
      res_op <= '0;
      ops_done <= '0;
    end else begin
      up <= 1'b1;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          alu_a <= in_a;
          alu_b <= in_b;
          alu_cin <= in_cin;
          alu_op <= in_op;
          cnt <= in_op[1] ? 8'(ARITH_WAIT) : 8'(LOGIC_WAIT);
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - 8'd1;
          if (capture) begin
            res_s <= alu_s;
            res_cout <= alu_cout & alu_op[1];
            res_op <= alu_op;
            res_valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          ops_done <= ops_done + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU64BIT_ISSUE_SEQ_CHECK_EN
  logic [W:0] model;
  logic mismatch;
  always_comb begin
    model = alu_op[1] ? {1'b0, alu_a} + {1'b0, alu_op[0] ? ~alu_b : alu_b} + (W+1)'(alu_cin)
                      : {1'b0, alu_op[0] ? alu_a ^ alu_b : ~(alu_a | alu_b)};
    mismatch = alu_s != model[W-1:0] || (alu_op[1] && alu_cout != model[W]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err <= 1'b0;
    else if (capture && mismatch) chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu64bit_issue_seq.sv
// tb_alu64bit_issue_seq: scoreboard bench for alu64bit_issue_seq with a behavioural ALU
module tb_alu64bit_issue_seq;
  localparam int W = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_cin = 1'b0, res_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, alu_a, alu_b, alu_s, res_s;
  logic [1:0] in_op = '0, alu_op, res_op;
  logic alu_cin, alu_cout, res_valid, res_cout, chk_err;
  logic [15:0] ops_done;
  logic fault = 1'b0;
  typedef struct packed {logic [1:0] op; logic c; logic [W-1:0] s;} exp_t;
  exp_t q[$];
  int errs = 0, checks = 0, exp_done = 0;
  always #5 clk = ~clk;
  alu64bit_issue_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_s(alu_s), .alu_cout(alu_cout), .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_cout(res_cout), .res_op(res_op), .ops_done(ops_done), .chk_err(chk_err)
  );
  // Logic ops report a junk carry of 1 so the sequencer's masking is exercised
  function automatic logic [W:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic [1:0] op);
    return op[1] ? {1'b0, a} + {1'b0, op[0] ? ~b : b} + (W+1)'(cin)
                 : {1'b1, op[0] ? a ^ b : ~(a | b)};
  endfunction
  always_comb {alu_cout, alu_s} = alu_f(alu_a, alu_b, alu_cin, alu_op) ^ {{W{1'b0}}, fault};
  task automatic check(string tag, logic [W:0] got, logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic [1:0] op,
                        logic [W-1:0] es, logic ec, int bp);
    exp_t e;
    int n;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_op = op;
    q.push_back({op, ec, es});
    @(negedge clk);
    in_valid = 1'b0;
    check("alu_a", alu_a, a);
    check("alu_op", alu_op, op);
    n = 0;
    while (!res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, op[1] ? 10 : 3);
    e = q.pop_front();
    check("res_s", res_s, e.s);
    check("res_cout", res_cout, e.c);
    check("res_op", res_op, e.op);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1; in_a = ~a; in_op = op ^ 2'b01;
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_res_valid", res_valid, 1);
      check("bp_res_s", res_s, e.s);
      check("bp_alu_a", alu_a, a);
      check("bp_ops_done", ops_done, exp_done);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_done++;
    check("ops_done", ops_done, exp_done);
    check("res_valid_clr", res_valid, 0);
    check("res_s_kept", res_s, e.s);
    check("in_ready_back", in_ready, 1);
  endtask
  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic [1:0] rop;
    logic rc;
    repeat (3) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_chk_err", chk_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    run_op('0, '0, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
    run_op(64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 2'b01, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10, 64'd0, 1'b1, 0);
    run_op(64'd5, 64'd7, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5);
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = 1'($urandom); rop = 2'($urandom);
      r = alu_f(ra, rb, rc, rop);
      run_op(ra, rb, rc, rop, r[W-1:0], r[W] & rop[1], i % 2);
    end
    @(negedge clk);
    in_valid = 1'b1; in_a = 64'd3; in_b = 64'd4; in_op = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_ops_done", ops_done, 0);
    exp_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_mid_rst", in_ready, 1);
    run_op(64'd100, 64'd23, 1'b1, 2'b10, 64'd124, 1'b0, 0);
    check("chk_err_clean", chk_err, 0);
`ifdef ALU64BIT_ISSUE_SEQ_CHECK_EN
    fault = 1'b1;
    run_op(64'hA, 64'h6, 1'b0, 2'b01, 64'hD, 1'b0, 0);
    fault = 1'b0;
    check("chk_err_set", chk_err, 1);
    run_op(64'd1, 64'd1, 1'b0, 2'b10, 64'd2, 1'b0, 0);
    check("chk_err_sticky", chk_err, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
